// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target fronting a parametrised register file with CIPO readback.
// Optional frame-error counter is built only when SPI_FRAME_ERR_CNT_EN is defined.
module spi_regfile_peripheral #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);
  localparam int              CNT_MAX    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int              CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, ncs_s, copi_s, sclk_rise, sclk_fall;

  // ncs synchroniser resets high so leaving reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples its neighbour's pre-edge value.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = !sclk_prev_q && sclk_s;
  assign sclk_fall = sclk_prev_q && !sclk_s;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W:0]   cmd_q;
  logic [DATA_W-1:0] din_q, dout_q;
  logic              cmd_done_q, commit_q, cipo_oe_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic              is_write, addr_ok, rd_load;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    rd_word  = '0;
    is_write = cmd_q[ADDR_W];
    addr     = cmd_q[ADDR_W-1:0];
    addr_ok  = {1'b0, addr} < NUM_REGS_L;
    rd_load  = (state_q == DATA) && cmd_done_q && !is_write && !sclk_rise && !ncs_s;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      cmd_done_q <= 1'b0;
      commit_q   <= 1'b0;
      cipo_oe_q  <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      commit_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!ncs_s) state_q <= CMD;
        end
        CMD: begin
          if (ncs_s) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            cmd_q <= {cmd_q[ADDR_W-1:0], copi_s};
            if (cnt_q == CNT_W'(ADDR_W)) begin
              cnt_q      <= '0;
              cmd_done_q <= 1'b1;
              state_q    <= DATA;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          // The final data rise takes priority over a simultaneous ncs deassert.
          if (sclk_rise) begin
            din_q <= {din_q[DATA_W-2:0], copi_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q   <= DONE;
              commit_q  <= is_write;
              cipo_oe_q <= 1'b0;
              dout_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (ncs_s) begin
            state_q   <= IDLE;
            cipo_oe_q <= 1'b0;
            dout_q    <= '0;
          end else if (rd_load) begin
            dout_q    <= rd_word;
            cipo_oe_q <= 1'b1;
          end else if (sclk_fall && cnt_q != '0) begin
            dout_q <= {dout_q[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (ncs_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is reset explicitly; unwritten registers must read back as 0.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (commit_q && addr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr == ADDR_W'(i)) regs_q[i] <= din_q;
        end
        wr_strobe_q <= 1'b1;
        wr_addr_q   <= addr;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = dout_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

`ifdef SPI_FRAME_ERR_CNT_EN
  logic       err_evt;
  logic [7:0] err_q;

  // Aborted frames and accesses beyond the implemented registers both count.
  always_comb begin
    err_evt = ((state_q == CMD) && ncs_s)
           || ((state_q == DATA) && ncs_s && !sclk_rise)
           || (commit_q && !addr_ok)
           || (rd_load && !addr_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_evt && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: default instance plus a wide-data instance sharing sclk/copi,
// driven by a vector table, random frames and a mid-frame reset, against a frame-level model.
module tb_spi_regfile_peripheral;
  localparam int HALF = 6;
  localparam int GAP  = 10;
`ifdef SPI_FRAME_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0;
  logic ncs0 = 1'b1, ncs1 = 1'b1;

  logic         cipo0, oe0, strb0;
  logic [39:0]  regs0;
  logic [6:0]   waddr0;
  logic [7:0]   err0;
  logic         cipo1, oe1, strb1;
  logic [255:0] regs1;
  logic [3:0]   waddr1;
  logic [7:0]   err1;

  always #5 clk = ~clk;

  spi_regfile_peripheral dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs0), .copi(copi),
    .cipo(cipo0), .cipo_oe(oe0), .regs_out(regs0), .wr_strobe(strb0),
    .wr_addr(waddr0), .err_count(err0)
  );

  spi_regfile_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs1), .copi(copi),
    .cipo(cipo1), .cipo_oe(oe1), .regs_out(regs1), .wr_strobe(strb1),
    .wr_addr(waddr1), .err_count(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int strb_tot0 = 0;
  int strb_tot1 = 0;

  always @(negedge clk) begin
    if (strb0) strb_tot0++;
    if (strb1) strb_tot1++;
  end

  // Reference model: register contents, last write address and error count per instance.
  logic [15:0] mreg [2][16];
  int merr[2];
  int mwaddr[2];
  int aw_of[2] = '{7, 4};
  int dw_of[2] = '{8, 16};
  int nr_of[2] = '{5, 16};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat(input int sel);
    logic [255:0] f;
    f = '0;
    for (int r = 0; r < nr_of[sel]; r++)
      for (int b = 0; b < dw_of[sel]; b++)
        f[r*dw_of[sel] + b] = mreg[sel][r][b];
    return f;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++) mreg[s][r] = '0;
      merr[s]   = 0;
      mwaddr[s] = 0;
    end
  endfunction

  // Drives one ncs-low window; stream[i] is the i-th bit sent. Records cipo/cipo_oe just
  // before each rise. rst_at >= 0 pulses rst_n at that rise and ends the window early.
  task automatic spi_frame(input int sel, input int nbits, input logic [39:0] stream,
                           input bit ncs_last, input int rst_at,
                           output logic [39:0] oe_m, output logic [39:0] cipo_m);
    oe_m   = '0;
    cipo_m = '0;
    if (sel == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      copi = stream[i];
      repeat (HALF) @(negedge clk);
      oe_m[i]   = (sel == 0) ? oe0 : oe1;
      cipo_m[i] = (sel == 0) ? cipo0 : cipo1;
      sclk = 1'b1;
      if (ncs_last && i == nbits - 1) begin
        ncs0 = 1'b1;
        ncs1 = 1'b1;
      end
      if (rst_at == i) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sclk = 1'b0; ncs0 = 1'b1; ncs1 = 1'b1; copi = 1'b0;
        rst_n = 1'b1;
        repeat (GAP) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ncs0 = 1'b1;
    ncs1 = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic run_frame(input int sel, input bit rw, input int addr, input logic [15:0] data,
                           input int nbits, input bit ncs_last,
                           output logic [15:0] rd_act, output int strobes);
    int aw, dw, nr, f, lim, s0, s1, other, exp_strobe;
    bit full, valid;
    logic [31:0] a;
    logic [15:0] rdv, mask;
    logic [39:0] stream, oe_m, cipo_m, exp_oe, exp_cipo;
    logic [255:0] act_flat;
    aw = aw_of[sel]; dw = dw_of[sel]; nr = nr_of[sel];
    f = 1 + aw + dw;
    a = addr;
    mask = 16'((32'd1 << dw) - 1);
    stream = 40'({$urandom(), $urandom()});
    stream[0] = rw;
    for (int k = 0; k < aw; k++) stream[1+k] = a[aw-1-k];
    for (int k = 0; k < dw; k++) stream[1+aw+k] = data[dw-1-k];

    full  = (nbits >= f);
    valid = (addr < nr);
    rdv   = '0;
    if (valid) rdv = mreg[sel][addr];
    exp_oe = '0; exp_cipo = '0;
    lim = (nbits < f) ? nbits : f;
    if (!rw)
      for (int i = aw + 1; i < lim; i++) begin
        exp_oe[i]   = 1'b1;
        exp_cipo[i] = rdv[dw-1-(i-aw-1)];
      end
    exp_strobe = (full && rw && valid) ? 1 : 0;

    s0 = strb_tot0; s1 = strb_tot1;
    spi_frame(sel, nbits, stream, ncs_last, -1, oe_m, cipo_m);

    if (!full) merr[sel]++;
    if (full && rw) begin
      if (valid) begin
        mreg[sel][addr] = data & mask;
        mwaddr[sel]     = addr;
      end else begin
        merr[sel]++;
      end
    end
    if (!rw && nbits >= aw + 1 && !valid) merr[sel]++;
    if (merr[sel] > 255) merr[sel] = 255;

    rd_act = '0;
    for (int j = 0; j < dw; j++) rd_act[dw-1-j] = cipo_m[1+aw+j];

    strobes = (sel == 0) ? strb_tot0 - s0 : strb_tot1 - s1;
    other   = (sel == 0) ? strb_tot1 - s1 : strb_tot0 - s0;
    check("cipo_oe_window", oe_m, exp_oe);
    if (exp_oe != '0) check("cipo_data", cipo_m & exp_oe, exp_cipo & exp_oe);
    check("cipo_oe_after_frame", (sel == 0) ? oe0 : oe1, 1'b0);
    check("wr_strobe_count", strobes, exp_strobe);
    check("other_instance_strobe", other, 0);
    if (sel == 0) begin
      check("wr_addr", waddr0, mwaddr[0]);
      act_flat = '0;
      act_flat[39:0] = regs0;
      check("err_count", err0, ERR_EN ? merr[0] : 0);
    end else begin
      check("wr_addr", waddr1, mwaddr[1]);
      act_flat = regs1;
      check("err_count", err1, ERR_EN ? merr[1] : 0);
    end
    check("regs_out", act_flat, model_flat(sel));
  endtask

  typedef struct {
    int          sel;
    logic        rw;
    int          addr;
    logic [15:0] data;
    int          nbits;
    logic        ncs_last;
    int          exp_strobe;
    int          exp_rd;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic [39:0] oe_m, cipo_m;
    int st, sel, addr, nbits, f;
    bit rw;
    logic [15:0] data;

    model_reset();
    vecs[0]  = '{0, 1'b1, 'h00, 16'h00A5, 16, 1'b0, 1, -1};
    vecs[1]  = '{0, 1'b1, 'h04, 16'h0080, 16, 1'b0, 1, -1};
    vecs[2]  = '{0, 1'b0, 'h04, 16'h0000, 16, 1'b0, 0, 'h80};
    vecs[3]  = '{0, 1'b1, 'h02, 16'h0011, 16, 1'b0, 1, -1};
    vecs[4]  = '{0, 1'b1, 'h02, 16'h0077, 10, 1'b0, 0, -1};
    vecs[5]  = '{0, 1'b0, 'h02, 16'h0000, 16, 1'b0, 0, 'h11};
    vecs[6]  = '{0, 1'b1, 'h7F, 16'h00FF, 16, 1'b0, 0, -1};
    vecs[7]  = '{0, 1'b0, 'h7F, 16'h0000, 16, 1'b0, 0, 'h00};
    vecs[8]  = '{0, 1'b1, 'h01, 16'h003C, 20, 1'b0, 1, -1};
    vecs[9]  = '{0, 1'b0, 'h01, 16'h0000, 16, 1'b0, 0, 'h3C};
    vecs[10] = '{0, 1'b1, 'h03, 16'h005A, 16, 1'b1, 1, -1};
    vecs[11] = '{0, 1'b0, 'h03, 16'h0000, 16, 1'b0, 0, 'h5A};
    vecs[12] = '{1, 1'b1, 'h0F, 16'hBEEF, 21, 1'b0, 1, -1};
    vecs[13] = '{1, 1'b0, 'h0F, 16'h0000, 21, 1'b0, 0, 'hBEEF};
    vecs[14] = '{1, 1'b0, 'h00, 16'h0000, 21, 1'b0, 0, 'h0000};
    vecs[15] = '{0, 1'b0, 'h00, 16'h0000, 16, 1'b0, 0, 'hA5};

    repeat (4) @(negedge clk);
    check("reset_regs0", regs0, '0);
    check("reset_regs1", regs1, '0);
    check("reset_cipo", {cipo0, cipo1}, 2'b00);
    check("reset_cipo_oe", {oe0, oe1}, 2'b00);
    check("reset_wr_strobe", {strb0, strb1}, 2'b00);
    check("reset_wr_addr", {waddr0, waddr1}, '0);
    check("reset_err_count", {err0, err1}, '0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      run_frame(vecs[v].sel, vecs[v].rw, vecs[v].addr, vecs[v].data,
                vecs[v].nbits, vecs[v].ncs_last, rd, st);
      check($sformatf("vec%0d_strobe", v), st, vecs[v].exp_strobe);
      if (vecs[v].exp_rd >= 0) check($sformatf("vec%0d_readback", v), rd, vecs[v].exp_rd);
    end

    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 1);
      rw  = 1'($urandom_range(0, 1));
      if (sel == 0) addr = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 127) : $urandom_range(0, 4);
      else          addr = $urandom_range(0, 15);
      data = 16'($urandom());
      f = 1 + aw_of[sel] + dw_of[sel];
      case ($urandom_range(0, 5))
        0:       nbits = $urandom_range(1, f - 1);
        1:       nbits = f + $urandom_range(1, 4);
        default: nbits = f;
      endcase
      run_frame(sel, rw, addr, data, nbits, 1'b0, rd, st);
    end

    run_frame(0, 1'b1, 0, 16'h00C3, 16, 1'b0, rd, st);
    run_frame(1, 1'b1, 15, 16'hBEEF, 21, 1'b0, rd, st);
    spi_frame(0, 16, '0, 1'b0, 11, oe_m, cipo_m);
    model_reset();
    check("rst_mid_oe_was_high", oe_m[11], 1'b1);
    check("rst_mid_regs0", regs0, '0);
    check("rst_mid_regs1", regs1, '0);
    check("rst_mid_cipo_oe", {oe0, cipo0}, 2'b00);
    check("rst_mid_wr_addr", {waddr0, waddr1}, '0);
    check("rst_mid_err_count", {err0, err1}, '0);
    run_frame(1, 1'b1, 15, 16'h1234, 21, 1'b0, rd, st);
    run_frame(1, 1'b0, 15, 16'h0000, 21, 1'b0, rd, st);
    check("post_reset_readback", rd, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
